// File: rtl/nec_divider_pipe.sv
// nec_divider_pipe: clock-enabled restoring divider resolving BPC quotient bits per ce cycle.
// Wide (2QW/QW) or narrow (QW/(QW/2)) operation, unsigned or signed with exact range overflow.
module nec_divider_pipe #(
    parameter int unsigned QW  = 16,
    parameter int unsigned BPC = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce,
    input  logic            start,
    input  logic            wide,
    input  logic            sgn,
    input  logic [2*QW-1:0] a,
    input  logic [QW-1:0]   b,
    output logic            busy,
    output logic            done,
    output logic            overflow,
    output logic            dbz,
    output logic [QW-1:0]   quot,
    output logic [QW-1:0]   rem
);
    localparam int unsigned DW = 2 * QW;
    localparam int unsigned HW = QW / 2;
    localparam int unsigned CW = $clog2(DW / BPC + 1);
    localparam logic [CW-1:0] LAST_W = CW'(DW / BPC - 1);
    localparam logic [CW-1:0] LAST_N = CW'(QW / BPC - 1);
    localparam logic [DW-1:0] ONE    = DW'(1);
    localparam logic [DW-1:0] ULIM_W = (ONE << QW) - ONE;
    localparam logic [DW-1:0] ULIM_N = (ONE << HW) - ONE;
    localparam logic [DW-1:0] PLIM_W = (ONE << (QW - 1)) - ONE;
    localparam logic [DW-1:0] PLIM_N = (ONE << (HW - 1)) - ONE;
    localparam logic [DW-1:0] NLIM_W = ONE << (QW - 1);
    localparam logic [DW-1:0] NLIM_N = ONE << (HW - 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;

    logic [CW-1:0] cnt, cnt_n;
    logic [QW:0]   acc, acc_n;
    logic [DW-1:0] dq, dq_n;
    logic [QW-1:0] bmag, bmag_n;
    logic          wide_r, wide_n, sgn_r, sgn_n, sa, sa_n, sb, sb_n;
    logic          done_n, ovf_n, dbz_n;
    logic [QW-1:0] quot_n, rem_n;

    logic [DW-1:0] a_act, amag_in;
    logic [QW-1:0] bmag_in, bneg_w;
    logic [HW-1:0] bneg_n;
    logic          sa_in, sb_in;

    // Narrow dividends are left-justified so the same MSB-first shift serves both widths.
    always_comb begin
        bneg_w = -b;
        bneg_n = -b[HW-1:0];
        if (wide) begin
            a_act   = a;
            sa_in   = sgn & a[DW-1];
            sb_in   = sgn & b[QW-1];
            bmag_in = sb_in ? bneg_w : b;
        end else begin
            a_act   = {a[QW-1:0], {QW{1'b0}}};
            sa_in   = sgn & a[QW-1];
            sb_in   = sgn & b[HW-1];
            bmag_in = {{(QW - HW){1'b0}}, (sb_in ? bneg_n : b[HW-1:0])};
        end
        amag_in = sa_in ? -a_act : a_act;
    end

    logic [QW:0]   acc_t, sh;
    logic [DW-1:0] dq_t, lim;
    logic [QW-1:0] mmag, qsig, rsig, qfmt, rfmt;
    logic          neg, last, ovf_t;

    always_comb begin
        acc_t = acc;
        dq_t  = dq;
        sh    = '0;
        for (int unsigned i = 0; i < BPC; i++) begin
            sh   = {acc_t[QW-1:0], dq_t[DW-1]};
            dq_t = {dq_t[DW-2:0], 1'b0};
            if (sh >= {1'b0, bmag}) begin
                acc_t   = sh - {1'b0, bmag};
                dq_t[0] = 1'b1;
            end else begin
                acc_t = sh;
            end
        end
        mmag = acc_t[QW-1:0];
        neg  = sa ^ sb;
        if (!sgn_r)   lim = wide_r ? ULIM_W : ULIM_N;
        else if (neg) lim = wide_r ? NLIM_W : NLIM_N;
        else          lim = wide_r ? PLIM_W : PLIM_N;
        ovf_t = dq_t > lim;
        qsig  = neg ? -dq_t[QW-1:0] : dq_t[QW-1:0];
        rsig  = sa ? -mmag : mmag;
        if (wide_r) begin
            qfmt = qsig;
            rfmt = rsig;
        end else begin
            qfmt = {{(QW - HW){sgn_r & qsig[HW-1]}}, qsig[HW-1:0]};
            rfmt = {{(QW - HW){sgn_r & rsig[HW-1]}}, rsig[HW-1:0]};
        end
        last = (cnt == (wide_r ? LAST_W : LAST_N));
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        dq_n    = dq;
        bmag_n  = bmag;
        wide_n  = wide_r;
        sgn_n   = sgn_r;
        sa_n    = sa;
        sb_n    = sb;
        done_n  = done;
        ovf_n   = overflow;
        dbz_n   = dbz;
        quot_n  = quot;
        rem_n   = rem;
        if (ce) begin
            done_n = 1'b0;
            if (start) begin
                wide_n = wide;
                sgn_n  = sgn;
                sa_n   = sa_in;
                sb_n   = sb_in;
                bmag_n = bmag_in;
                dq_n   = amag_in;
                acc_n  = '0;
                cnt_n  = '0;
                ovf_n  = 1'b0;
                if (bmag_in == '0) begin
                    dbz_n   = 1'b1;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    dbz_n   = 1'b0;
                    state_n = RUN;
                end
            end else if (state == RUN) begin
                acc_n = acc_t;
                dq_n  = dq_t;
                cnt_n = cnt + CW'(1);
                if (last) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    ovf_n   = ovf_t;
                    if (!ovf_t) begin
                        quot_n = qfmt;
                        rem_n  = rfmt;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            dq       <= '0;
            bmag     <= '0;
            wide_r   <= 1'b0;
            sgn_r    <= 1'b0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            dbz      <= 1'b0;
            quot     <= '0;
            rem      <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            acc      <= acc_n;
            dq       <= dq_n;
            bmag     <= bmag_n;
            wide_r   <= wide_n;
            sgn_r    <= sgn_n;
            sa       <= sa_n;
            sb       <= sb_n;
            done     <= done_n;
            overflow <= ovf_n;
            dbz      <= dbz_n;
            quot     <= quot_n;
            rem      <= rem_n;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: doc/nec_divider_pipe.md
Name: nec_divider_pipe

Overview:
Parametrised, clock-enabled sequential restoring divider for the NEC Vxx execution unit. It is the generalised successor to the fixed 32/16 divider. It supports:
- configurable quotient width
- configurable quotient bits resolved per ce cycle
- unsigned and signed modes, selected per operation
- exact signed-range overflow detection
Sits beside the ALU and serves DIVU/DIV in both wide (2N/N) and narrow (N/(N/2)) forms.

Parameters:
QW, 16, wide-mode quotient/remainder width in bits; dividend is 2*QW. Must be even and ≥ 8.
BPC, 1, quotient bits resolved per ce cycle. Legal values: 1, 2, 4. Must divide QW.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high; overrides ce
ce  in  1  clock enable; all state advances only when ce=1 (except reset)
start  in  1  begin operation; sampled on a ce cycle
wide  in  1  1: dividend a[2QW-1:0] / divisor b[QW-1:0]; 0: dividend a[QW-1:0] / divisor b[QW/2-1:0]
sgn  in  1  1: operands are two's complement; 0: unsigned
a  in  2*QW  dividend
b  in  QW  divisor
busy  out  1  iteration in progress
done  out  1  completion strobe
overflow  out  1  quotient out of range for the selected mode
dbz  out  1  divide by zero
quot  out  QW  quotient, two's complement when sgn=1
rem  out  QW  remainder, two's complement when sgn=1

Behaviour:
- Reset: busy, done, overflow, dbz = 0; quot, rem = 0; iteration counter = 0. Reset mid-operation aborts the operation with no done.
- Active width: D = 2QW (wide) or QW (narrow); divisor width V = D/2; result width R = V.
- Operand capture at start (ce=1): wide, sgn, and the magnitudes |a| and |b| over the active widths are latched, together with sign_a and sign_b. sign_a/sign_b are the active-width MSBs when sgn=1, otherwise 0. Inputs may change freely afterwards.
- Divide by zero: if the active divisor bits are 0 at start, then dbz=1, done=1 on the next ce edge, busy stays 0, overflow=0, and quot/rem hold their previous values.
- Otherwise at start: busy=1, dbz=0, overflow=0, counter=0.
- Iteration (FSM states IDLE, RUN):
  - Each ce cycle in RUN shifts BPC dividend bits into a (V+1)-bit accumulator.
  - Each bit does a compare/subtract against |b| and shifts the quotient bit into a D-bit quotient register. BPC stages are chained combinationally.
  - RUN lasts exactly D/BPC ce cycles: 32 for QW=16 wide with BPC=1, 16 for narrow.
  - On the final cycle: busy=0, done=1, and results are written.
- Result formation:
  - quotient magnitude Q (D bits), remainder magnitude M (V bits)
  - quot = (sign_a ^ sign_b) ? -Q : Q, truncated toward zero
  - rem = sign_a ? -M : M; remainder takes the dividend's sign
  - R-bit values are sign-extended (sgn=1) or zero-extended (sgn=0) to QW
- Overflow:
  - unsigned: Q > 2^R - 1
  - signed, positive result: Q > 2^(R-1) - 1
  - signed, negative result: Q > 2^(R-1)
  - On overflow: overflow=1, done=1, and quot/rem hold their previous values (the CPU raises INT0).
- done timing: high for exactly one ce-enabled cycle; cleared at the next ce=1 edge. While ce=0, all outputs hold.
- start while busy: aborts the current operation and restarts with the new operands; no done for the aborted one.
- start coincident with final iteration: start wins; no done for the old operation.
- ce=0 during RUN: counter, accumulator and busy are frozen. Latency counts ce cycles, not clocks.
- Quotient/remainder are valid whenever done=1 and overflow=0 and dbz=0, and remain stable until the next successful completion.

Test Plan:
1. QW=16, BPC=1, unsigned wide: a=0x00010005, b=0x0002 -> after 32 ce cycles, done=1, quot=0x8002, rem=0x0001, overflow=0; busy high for exactly 32 ce cycles.
2. Signed wide: a=0xFFFFFFF9 (-7), b=0x0002 -> quot=0xFFFD (-3), rem=0xFFFF (-1). Also a=0x00000007, b=0xFFFE -> quot=0xFFFD, rem=0x0001.
3. Signed overflow boundary: a=0x00008000, b=0x0001 -> overflow=1, quot/rem unchanged. a=0xFFFF8000, b=0x0001 -> quot=0x8000, overflow=0. Unsigned a=0x00010000, b=0x0001 -> overflow=1.
4. Narrow: sgn=0, a=0x0064, b=0x07 -> quot=0x000E, rem=0x0002 after 16 ce cycles. sgn=1, a=0xFF9C (-100), b=0x07 -> quot=0xFFF2, rem=0xFFFE. a=0x0100, b=0x01 -> overflow=1.
5. Divide by zero: b=0 (wide), and b=0x1200 narrow (low byte 0) -> dbz=1, done one ce later, busy never asserted.
6. Control: ce toggled randomly during test 1 -> identical results after 32 enabled cycles; start mid-run -> only the second result reported; reset at cycle 10 -> all outputs 0, no done; BPC=2 and BPC=4 builds -> tests 1–4 pass with latency D/BPC.
